// File: rtl/mips_exec_sequencer_if.sv
// Sequencer bus: board controls, core handshake and display/status signals.
// The sequencer sits on the slave side; the board/core drives the master side.
interface mips_exec_sequencer_if #(
    parameter int AW = 5,
    parameter int CW = 8
);
    logic          start;
    logic          step;
    logic          pause;
    logic          clear;
    logic          halt;
    logic          pc_branch;
    logic [AW-1:0] next_inst_addr;
    logic [AW-1:0] curr_inst_addr;
    logic          core_en;
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] instr_count;
    logic [CW-1:0] branch_count;

    modport master (
        output start, step, pause, clear, halt, pc_branch, next_inst_addr,
        input  curr_inst_addr, core_en, state, busy, done, timeout,
               instr_count, branch_count
    );

    modport slave (
        input  start, step, pause, clear, halt, pc_branch, next_inst_addr,
        output curr_inst_addr, core_en, state, busy, done, timeout,
               instr_count, branch_count
    );
endinterface

// File: rtl/mips_exec_sequencer.sv
// Run controller for the single-cycle MIPS core: owns the PC, gates commits
// through core_en, and keeps the instruction/branch counters and watchdog.
module mips_exec_sequencer #(
    parameter int AW        = 5,
    parameter int CW        = 8,
    parameter int MAX_INSTR = 255
) (
    input logic                 clk,
    input logic                 reset,
    mips_exec_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STEP    = 3'd2,
        HALTED  = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_INSTR);

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] instr_q;
    logic [CW-1:0] branch_q;
    logic          active;
    logic [CW-1:0] instr_inc;
    logic [CW-1:0] branch_inc;
    logic          watchdog;

    assign active     = (state_q == RUN) || (state_q == STEP);
    assign instr_inc  = instr_q + 1'b1;
    assign branch_inc = (bus.pc_branch && (branch_q != '1)) ? branch_q + 1'b1 : branch_q;
    // The watchdog looks at the count this commit is about to produce.
    assign watchdog   = (instr_inc == MAX_COUNT);

    assign bus.core_en        = active && !bus.halt && !bus.clear;
    assign bus.curr_inst_addr = pc_q;
    assign bus.state          = state_q;
    assign bus.busy           = active;
    assign bus.done           = (state_q == HALTED);
    assign bus.timeout        = (state_q == TIMEOUT);
    assign bus.instr_count    = instr_q;
    assign bus.branch_count   = branch_q;

    // HALT in RUN/STEP never commits: PC parks on the HALT address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            branch_q <= '0;
        end else if (bus.clear) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            branch_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                    end else if (bus.step) begin
                        state_q <= STEP;
                    end
                end
                RUN, STEP: begin
                    if (bus.halt) begin
                        state_q <= HALTED;
                    end else begin
                        pc_q     <= bus.next_inst_addr;
                        instr_q  <= instr_inc;
                        branch_q <= branch_inc;
                        if (watchdog) begin
                            state_q <= TIMEOUT;
                        end else if ((state_q == STEP) || bus.pause) begin
                            state_q <= IDLE;
                        end
                    end
                end
                HALTED, TIMEOUT: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_exec_sequencer.sv
// Bench for mips_exec_sequencer: directed scenarios plus random control
// pulses, all checked each cycle against a flag-based behavioural model.
module tb_mips_exec_sequencer;
    localparam int AW        = 5;
    localparam int CW        = 8;
    localparam int MAX_INSTR = 12;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    int m_pc, m_ic, m_bc;
    bit m_run, m_single, m_halted, m_expired;

    mips_exec_sequencer_if #(.AW(AW), .CW(CW)) bus ();

    mips_exec_sequencer #(.AW(AW), .CW(CW), .MAX_INSTR(MAX_INSTR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_pc = 0; m_ic = 0; m_bc = 0;
        m_run = 0; m_single = 0; m_halted = 0; m_expired = 0;
    endtask

    function automatic int expectedState();
        if (m_halted)  return 3;
        if (m_expired) return 4;
        if (m_run)     return 1;
        if (m_single)  return 2;
        return 0;
    endfunction

    // One rising edge of the reference: a commit happens when the machine is
    // running or stepping, the core is not at HALT and no clear is present.
    task automatic modelEdge();
        bit was_active;
        was_active = m_run || m_single;
        if (bus.clear) begin
            modelReset();
        end else if (!(m_halted || m_expired)) begin
            if (was_active && bus.halt) begin
                m_run = 0; m_single = 0; m_halted = 1;
            end else if (was_active) begin
                m_pc = int'(bus.next_inst_addr);
                m_ic = (m_ic + 1) % 256;
                if (bus.pc_branch && m_bc < 255) m_bc++;
                if (m_ic == MAX_INSTR) begin
                    m_run = 0; m_single = 0; m_expired = 1;
                end else if (m_single || bus.pause) begin
                    m_run = 0; m_single = 0;
                end
            end else if (bus.start) begin
                m_run = 1;
            end else if (bus.step) begin
                m_single = 1;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        int st;
        bit en;
        st = expectedState();
        en = (m_run || m_single) && !bus.halt && !bus.clear;
        checkOutput({tag, ".pc"},      int'(bus.curr_inst_addr), m_pc);
        checkOutput({tag, ".state"},   int'(bus.state), st);
        checkOutput({tag, ".core_en"}, int'(bus.core_en), int'(en));
        checkOutput({tag, ".busy"},    int'(bus.busy), int'(st == 1 || st == 2));
        checkOutput({tag, ".done"},    int'(bus.done), int'(st == 3));
        checkOutput({tag, ".timeout"}, int'(bus.timeout), int'(st == 4));
        checkOutput({tag, ".icount"},  int'(bus.instr_count), m_ic);
        checkOutput({tag, ".bcount"},  int'(bus.branch_count), m_bc);
    endtask

    // Drive one cycle of inputs at the falling edge, check, then clock the model.
    task automatic applyStimulus(input logic st, input logic sp, input logic pa,
                                 input logic cl, input logic ha, input logic br,
                                 input logic [AW-1:0] nx, input string tag);
        @(negedge clk);
        bus.start = st; bus.step = sp; bus.pause = pa; bus.clear = cl;
        bus.halt = ha; bus.pc_branch = br; bus.next_inst_addr = nx;
        #1;
        checkAll(tag);
        @(posedge clk);
        modelEdge();
    endtask

    function automatic logic [AW-1:0] nextSeq();
        return AW'(m_pc + 1);
    endfunction

    initial begin
        reset = 1'b0;
        bus.start = 0; bus.step = 0; bus.pause = 0; bus.clear = 0;
        bus.halt = 0; bus.pc_branch = 0; bus.next_inst_addr = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.pc",      int'(bus.curr_inst_addr), 0);
        checkOutput("rst.state",   int'(bus.state), 0);
        checkOutput("rst.core_en", int'(bus.core_en), 0);
        checkOutput("rst.busy",    int'(bus.busy), 0);
        checkOutput("rst.done",    int'(bus.done), 0);
        checkOutput("rst.timeout", int'(bus.timeout), 0);
        checkOutput("rst.icount",  int'(bus.instr_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // Async reset while running at PC=7 with seven commits.
        applyStimulus(1, 0, 0, 0, 0, 0, '0, "t1.start");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, nextSeq(), "t1.run");
        #1;
        checkOutput("t1.pc_before", int'(bus.curr_inst_addr), 7);
        @(negedge clk);
        bus.next_inst_addr = '0;
        reset = 1'b0;
        #1;
        checkOutput("t1.pc",      int'(bus.curr_inst_addr), 0);
        checkOutput("t1.state",   int'(bus.state), 0);
        checkOutput("t1.icount",  int'(bus.instr_count), 0);
        checkOutput("t1.core_en", int'(bus.core_en), 0);
        modelReset();
        #1;
        reset = 1'b1;

        // HALT at address 3.
        applyStimulus(0, 0, 0, 1, 0, 0, '0, "t2.clear");
        applyStimulus(1, 0, 0, 0, 0, 0, '0, "t2.start");
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 0, 0, (m_pc == 3), 0, nextSeq(), "t2.run");
        #1;
        checkOutput("t2.pc",      int'(bus.curr_inst_addr), 3);
        checkOutput("t2.done",    int'(bus.done), 1);
        checkOutput("t2.icount",  int'(bus.instr_count), 3);
        checkOutput("t2.core_en", int'(bus.core_en), 0);

        // Two single steps three cycles apart.
        applyStimulus(0, 0, 0, 1, 0, 0, '0, "t3.clear");
        applyStimulus(0, 1, 0, 0, 0, 0, nextSeq(), "t3.step");
        applyStimulus(0, 0, 0, 0, 0, 0, nextSeq(), "t3.idle");
        applyStimulus(0, 0, 0, 0, 0, 0, nextSeq(), "t3.idle");
        applyStimulus(0, 1, 0, 0, 0, 0, nextSeq(), "t3.step");
        applyStimulus(0, 0, 0, 0, 0, 0, nextSeq(), "t3.idle");
        applyStimulus(0, 0, 0, 0, 0, 0, nextSeq(), "t3.idle");
        #1;
        checkOutput("t3.pc",     int'(bus.curr_inst_addr), 2);
        checkOutput("t3.icount", int'(bus.instr_count), 2);
        checkOutput("t3.state",  int'(bus.state), 0);

        // Taken branch from PC=2 to 5.
        applyStimulus(0, 0, 0, 1, 0, 0, '0, "t4.clear");
        applyStimulus(1, 0, 0, 0, 0, 0, '0, "t4.start");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd1, "t4.run");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd2, "t4.run");
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd5, "t4.branch");
        #1;
        checkOutput("t4.pc",     int'(bus.curr_inst_addr), 5);
        checkOutput("t4.bcount", int'(bus.branch_count), 1);
        checkOutput("t4.icount", int'(bus.instr_count), 3);

        // Branch loop with no HALT runs into the watchdog.
        applyStimulus(0, 0, 0, 1, 0, 0, '0, "t5.clear");
        applyStimulus(1, 0, 0, 0, 0, 0, '0, "t5.start");
        for (int i = 0; i < MAX_INSTR + 2; i++) applyStimulus(0, 0, 0, 0, 0, 1, '0, "t5.loop");
        #1;
        checkOutput("t5.timeout", int'(bus.timeout), 1);
        checkOutput("t5.icount",  int'(bus.instr_count), MAX_INSTR);
        checkOutput("t5.bcount",  int'(bus.branch_count), MAX_INSTR);
        checkOutput("t5.core_en", int'(bus.core_en), 0);

        // Pause still commits; clear beats start in HALTED.
        applyStimulus(0, 0, 0, 1, 0, 0, '0, "t6.clear");
        applyStimulus(1, 0, 0, 0, 0, 0, '0, "t6.start");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd1, "t6.run");
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd2, "t6.pause");
        #1;
        checkOutput("t6.pause_pc",    int'(bus.curr_inst_addr), 2);
        checkOutput("t6.pause_state", int'(bus.state), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0, "t6.start2");
        applyStimulus(0, 0, 0, 0, 1, 0, 5'd9, "t6.halt");
        applyStimulus(1, 0, 0, 1, 0, 0, '0, "t6.clrstart");
        #1;
        checkOutput("t6.state",  int'(bus.state), 0);
        checkOutput("t6.pc",     int'(bus.curr_inst_addr), 0);
        checkOutput("t6.icount", int'(bus.instr_count), 0);

        // Random control pulses and core responses.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0),
                          AW'($urandom_range(0, 31)), "rnd");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, '0, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
